// File: rtl/bitmask_pkg.sv
// Shared types and helpers for the bitmask immediate pipeline.
package bitmask_pkg;

  // Widest datapath the element generator produces.
  localparam int MAX_W     = 64;
  // Tag storage in the stage-1 entry; instances use the low TAG_W bits.
  localparam int TAG_MAX_W = 16;

  typedef enum logic {
    MODE_BITFIELD = 1'b0,
    MODE_LOGICAL  = 1'b1
  } mask_mode_t;

  // Decoded request held in stage 1.
  typedef struct packed {
    logic [TAG_MAX_W-1:0] tag;
    logic [5:0]           s;
    logic [5:0]           r;
    logic [2:0]           len;
    logic                 illegal;
    mask_mode_t           mode;
  } s1_entry_t;

  // Repeat the low (1 << len) bits of elem across the full MAX_W width.
  function automatic logic [MAX_W-1:0] replicate_elem(input logic [MAX_W-1:0] elem,
                                                      input logic [2:0]       len);
    logic [MAX_W-1:0] rep;
    case (len)
      3'd0:    rep = {64{elem[0]}};
      3'd1:    rep = {32{elem[1:0]}};
      3'd2:    rep = {16{elem[3:0]}};
      3'd3:    rep = {8{elem[7:0]}};
      3'd4:    rep = {4{elem[15:0]}};
      3'd5:    rep = {2{elem[31:0]}};
      default: rep = elem;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/bitmask_elem_gen.sv
// Builds one element of the wraparound and top masks for a decoded s/r/len.
// Outputs are 64 bits wide with everything above the element size zero.
module bitmask_elem_gen
  import bitmask_pkg::*;
(
  input  logic [5:0]       s,
  input  logic [5:0]       r,
  input  logic [2:0]       len,
  output logic [MAX_W-1:0] welem,
  output logic [MAX_W-1:0] telem
);

  logic [6:0]       esize;
  logic [5:0]       levels;
  logic [5:0]       d;
  logic [MAX_W-1:0] ones_w;
  logic [MAX_W-1:0] emask;

  // ones(s+1) rotated right by r inside esize bits; ones(d+1) for the top mask.
  // A shift of 64 yields zero, so ones(64) and the 64-bit element mask fall out naturally.
  always_comb begin
    esize  = 7'd1 << len;
    levels = 6'(esize - 7'd1);
    ones_w = ~({MAX_W{1'b1}} << ({1'b0, s} + 7'd1));
    emask  = ~({MAX_W{1'b1}} << esize);
    welem  = ((ones_w >> r) | (ones_w << (esize - {1'b0, r}))) & emask;
    d      = (s - r) & levels;
    telem  = ~({MAX_W{1'b1}} << ({1'b0, d} + 7'd1));
  end

endmodule

// File: rtl/bitmask_imm_pipe.sv
// Two-stage DecodeBitMasks pipeline: S1 decodes element size and legality,
// S2 builds, replicates and registers the wraparound/top masks.
// M must be 32 or 64; TAG_W must not exceed TAG_MAX_W.
//
// Flow control: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its request (tag and fields) stable while
// valid is high and ready is low; ready may depend combinationally on
// out_ready. The consumer sees outputs held stable while out_valid & ~out_ready.
module bitmask_imm_pipe
  import bitmask_pkg::*;
#(
  parameter int M     = 64,
  parameter int TAG_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_logical,
  input  logic             in_immN,
  input  logic [5:0]       in_imms,
  input  logic [5:0]       in_immr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [M-1:0]     out_wmask,
  output logic [M-1:0]     out_tmask,
  output logic             out_illegal
);

  // Stage registers
  s1_entry_t        s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [M-1:0]     out_wmask_q, out_wmask_d;
  logic [M-1:0]     out_tmask_q, out_tmask_d;
  logic             out_illegal_q, out_illegal_d;

  // Handshake
  logic s2_adv, s1_adv, accept;

  // Stage-1 decode of the incoming request
  s1_entry_t  entry_c;
  logic [6:0] val7;
  logic [6:0] esize_c;
  logic [5:0] levels_c;

  // Stage-2 mask generation
  logic [MAX_W-1:0] welem, telem;
  logic [MAX_W-1:0] wrep, trep;

  // S2 moves when it is empty or being drained; S1 moves when it is empty or S2 moves.
  always_comb begin
    s2_adv = ~out_valid_q | out_ready;
    s1_adv = ~s1_valid_q | s2_adv;
    accept = in_valid & s1_adv & ~flush;
  end

  assign in_ready = s1_adv;

  // Element-size detection, legality and field masking for the incoming request.
  always_comb begin
    val7 = {in_immN, ~in_imms};
    entry_c = '0;
    for (int i = 0; i < 7; i++) begin
      if (val7[i]) entry_c.len = 3'(i);
    end
    esize_c  = 7'd1 << entry_c.len;
    levels_c = 6'(esize_c - 7'd1);
    // A one-bit element (or no set bit at all) is reserved.
    entry_c.illegal = (entry_c.len == 3'd0);
    // Element wider than the datapath, e.g. N=1 on a 32-bit instance.
    if (int'(esize_c) > M) entry_c.illegal = 1'b1;
    // An all-ones logical element would produce an all-ones immediate.
    if (in_logical && ((in_imms & levels_c) == levels_c)) entry_c.illegal = 1'b1;
    entry_c.s    = in_imms & levels_c;
    entry_c.r    = in_immr & levels_c;
    entry_c.mode = in_logical ? MODE_LOGICAL : MODE_BITFIELD;
    entry_c.tag[TAG_W-1:0] = in_tag;
  end

  // Next state for S1: refill on accept, empty when the entry leaves unreplaced, clear on flush.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) s1_valid_d = accept;
    if (accept) s1_d = entry_c;
    if (flush)  s1_valid_d = 1'b0;
  end

  // S1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  bitmask_elem_gen u_elem_gen (
    .s     (s1_q.s),
    .r     (s1_q.r),
    .len   (s1_q.len),
    .welem (welem),
    .telem (telem)
  );

  // Replicate the element across the datapath and zero the masks on illegal encodings.
  always_comb begin
    wrep          = replicate_elem(welem, s1_q.len);
    trep          = replicate_elem(telem, s1_q.len);
    out_valid_d   = out_valid_q;
    out_tag_d     = out_tag_q;
    out_wmask_d   = out_wmask_q;
    out_tmask_d   = out_tmask_q;
    out_illegal_d = out_illegal_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_tag_d     = s1_q.tag[TAG_W-1:0];
        out_illegal_d = s1_q.illegal;
        out_wmask_d   = s1_q.illegal ? '0 : wrep[M-1:0];
        out_tmask_d   = s1_q.illegal ? '0 : trep[M-1:0];
      end
    end
    if (flush) out_valid_d = 1'b0;
  end

  // S2 / output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_tag_q     <= '0;
      out_wmask_q   <= '0;
      out_tmask_q   <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_tag_q     <= out_tag_d;
      out_wmask_q   <= out_wmask_d;
      out_tmask_q   <= out_tmask_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_tag     = out_tag_q;
  assign out_wmask   = out_wmask_q;
  assign out_tmask   = out_tmask_q;
  assign out_illegal = out_illegal_q;

  // Mode is carried for debug visibility; upper tag bits and the replicated
  // upper half on a 32-bit instance are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{s1_q.mode, s1_q.tag, wrep, trep};

endmodule

// File: tb/tb_bitmask_imm_pipe.sv
// Bench for bitmask_imm_pipe: a 64-bit and a 32-bit instance share stimulus
// and are checked against a bit-by-bit DecodeBitMasks reference model.
module tb_bitmask_imm_pipe;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_logical, in_immN, out_ready;
  logic [6:0]  in_tag;
  logic [5:0]  in_imms, in_immr;
  logic        in_ready, out_valid, out_illegal;
  logic [6:0]  out_tag;
  logic [63:0] out_wmask, out_tmask;
  logic        in_ready32, out_valid32, out_illegal32;
  logic [6:0]  out_tag32;
  logic [31:0] out_wmask32, out_tmask32;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   recv64  = 0;
  bit   rand_ready = 1'b0;
  bit   mon_en     = 1'b1;
  bit   stall_done = 1'b0;

  // Expected entries: {tag[6:0], illegal, wmask[63:0], tmask[63:0]}
  logic [135:0] exp_q[$];
  logic [135:0] exp32_q[$];

  always #5 clk = ~clk;

  bitmask_imm_pipe #(.M(64), .TAG_W(7)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_logical(in_logical), .in_immN(in_immN), .in_imms(in_imms), .in_immr(in_immr),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_wmask(out_wmask), .out_tmask(out_tmask), .out_illegal(out_illegal)
  );

  bitmask_imm_pipe #(.M(32), .TAG_W(7)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_tag(in_tag),
    .in_logical(in_logical), .in_immN(in_immN), .in_imms(in_imms), .in_immr(in_immr),
    .out_valid(out_valid32), .out_ready(out_ready), .out_tag(out_tag32),
    .out_wmask(out_wmask32), .out_tmask(out_tmask32), .out_illegal(out_illegal32)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", name, obs, exp);
    end
  endtask

  // Reference: element size from the top set bit of {N, ~imms}, then each
  // output bit decided from its position inside the element.
  function automatic logic [135:0] model(input int m, input logic [6:0] tag, input logic lg,
                                         input logic n, input logic [5:0] imms,
                                         input logic [5:0] immr);
    int val, len, esize, s, r, d, j;
    logic ill;
    logic [63:0] w, t;
    val   = (n ? 64 : 0) + (63 - int'(imms));
    len   = -1;
    esize = 1;
    for (int i = 0; i < 7; i++) if (((val >> i) & 1) == 1) len = i;
    ill = (len <= 0);
    w = '0;
    t = '0;
    if (!ill) begin
      esize = 1 << len;
      if (esize > m) ill = 1'b1;
    end
    if (!ill && lg && ((int'(imms) % esize) == esize - 1)) ill = 1'b1;
    if (!ill) begin
      s = int'(imms) % esize;
      r = int'(immr) % esize;
      d = (s - r + esize) % esize;
      for (int i = 0; i < m; i++) begin
        j    = i % esize;
        w[i] = (((j + r) % esize) <= s);
        t[i] = (j <= d);
      end
    end
    return {tag, ill, w, t};
  endfunction

  // Scoreboard: compare every transferred result against the queue head.
  always @(negedge clk) begin
    logic [135:0] e;
    if (!rst && mon_en) begin
      if (out_valid && out_ready) begin
        recv64++;
        if (exp_q.size() == 0) check("unexpected_out64", 64'(out_tag), 64'h7f00);
        else begin
          e = exp_q.pop_front();
          check("tag64",     64'(out_tag),     64'(e[135:129]));
          check("illegal64", 64'(out_illegal), 64'(e[128]));
          check("wmask64",   out_wmask,        e[127:64]);
          check("tmask64",   out_tmask,        e[63:0]);
        end
      end
      if (out_valid32 && out_ready) begin
        if (exp32_q.size() == 0) check("unexpected_out32", 64'(out_tag32), 64'h7f00);
        else begin
          e = exp32_q.pop_front();
          check("tag32",     64'(out_tag32),     64'(e[135:129]));
          check("illegal32", 64'(out_illegal32), 64'(e[128]));
          check("wmask32",   64'(out_wmask32),   e[127:64]);
          check("tmask32",   64'(out_tmask32),   e[63:0]);
        end
      end
    end
  end

  // Random backpressure
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input logic [6:0] tag, input logic lg, input logic n,
                      input logic [5:0] s, input logic [5:0] r,
                      input logic [135:0] e64, input logic [135:0] e32);
    bit acc = 1'b0;
    in_valid = 1'b1; in_tag = tag; in_logical = lg; in_immN = n; in_imms = s; in_immr = r;
    for (int k = 0; k < 60 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready && in_ready32 && !flush;
      if (acc) begin
        exp_q.push_back(e64);
        exp32_q.push_back(e32);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 64'(tag), 64'h7f00);
  endtask

  task automatic send_model(input logic [6:0] tag, input logic lg, input logic n,
                            input logic [5:0] s, input logic [5:0] r);
    send(tag, lg, n, s, r, model(64, tag, lg, n, s, r), model(32, tag, lg, n, s, r));
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || exp32_q.size() != 0) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(exp_q.size() + exp32_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    bit seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_tag = '0; in_logical = 1'b0;
    in_immN = 1'b0; in_imms = '0; in_immr = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid",   64'(out_valid),   64'd0);
    check("rst_out_tag",     64'(out_tag),     64'd0);
    check("rst_out_wmask",   out_wmask,        64'd0);
    check("rst_out_tmask",   out_tmask,        64'd0);
    check("rst_out_illegal", 64'(out_illegal), 64'd0);
    check("rst_in_ready",    64'(in_ready),    64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed encodings with hand-computed masks
    send(7'd1, 1'b1, 1'b1, 6'b000000, 6'b000000,
         {7'd1, 1'b0, 64'h0000000000000001, 64'h0000000000000001},
         model(32, 7'd1, 1'b1, 1'b1, 6'b000000, 6'b000000));
    send(7'd2, 1'b1, 1'b0, 6'b111100, 6'b000000,
         {7'd2, 1'b0, 64'h5555555555555555, 64'h5555555555555555},
         {7'd2, 1'b0, 64'h0000000055555555, 64'h0000000055555555});
    send(7'd3, 1'b1, 1'b0, 6'b000111, 6'b000001,
         {7'd3, 1'b0, 64'h8000007F8000007F, 64'h0000007F0000007F},
         {7'd3, 1'b0, 64'h000000008000007F, 64'h000000000000007F});
    send(7'd4, 1'b1, 1'b0, 6'b111111, 6'b000000, {7'd4, 1'b1, 128'd0}, {7'd4, 1'b1, 128'd0});
    send(7'd5, 1'b1, 1'b1, 6'b111111, 6'b000011, {7'd5, 1'b1, 128'd0}, {7'd5, 1'b1, 128'd0});
    send(7'd6, 1'b0, 1'b1, 6'b000000, 6'b000000,
         {7'd6, 1'b0, 64'h0000000000000001, 64'h0000000000000001},
         {7'd6, 1'b1, 128'd0});
    send(7'd7, 1'b0, 1'b1, 6'b000111, 6'b000000,
         {7'd7, 1'b0, 64'h00000000000000FF, 64'h00000000000000FF},
         {7'd7, 1'b1, 128'd0});
    send(7'd8, 1'b0, 1'b1, 6'b000111, 6'b001000,
         {7'd8, 1'b0, 64'hFF00000000000000, 64'hFFFFFFFFFFFFFFFF},
         {7'd8, 1'b1, 128'd0});
    wait_drain("drain_directed");

    // Stall: four back-to-back requests against a blocked consumer
    out_ready = 1'b0;
    base = recv64;
    stall_done = 1'b0;
    fork
      begin
        for (int t = 1; t <= 4; t++)
          send_model(7'(t), 1'b0, 1'b0, 6'(t + 2), 6'(t));
        stall_done = 1'b1;
      end
    join_none
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("stall_out_valid_seen", 64'(seen), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready),  64'd0);
      check("stall_valid",    64'(out_valid), 64'd1);
      check("stall_tag",      64'(out_tag),   64'd1);
      check("stall_wmask",    out_wmask,      exp_q[0][127:64]);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && !stall_done; k++) begin
      @(posedge clk); #1;
    end
    wait_drain("drain_stall");
    check("stall_count", 64'(recv64 - base), 64'd4);

    // Flush with two entries in flight and a new request in the same cycle
    out_ready = 1'b0;
    send_model(7'd20, 1'b1, 1'b0, 6'b000011, 6'b000001);
    send_model(7'd21, 1'b0, 1'b1, 6'b001111, 6'b000100);
    mon_en = 1'b0;
    exp_q.delete();
    exp32_q.delete();
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_tag = 7'd22; in_logical = 1'b1; in_immN = 1'b0;
    in_imms = 6'b000001; in_immr = 6'b000000;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; mon_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("flush_no_out", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Randomized stream with random backpressure and gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_model(7'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("drain_random");

    // Asynchronous reset in the middle of the stream
    out_ready = 1'b0;
    send_model(7'd10, 1'b1, 1'b0, 6'b100001, 6'b000010);
    send_model(7'd11, 1'b0, 1'b0, 6'b010001, 6'b000111);
    @(negedge clk);
    check("rst_mid_valid_before", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_tag",   64'(out_tag),   64'd0);
    exp_q.delete();
    exp32_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rel_in_ready", 64'(in_ready),  64'd1);
    check("rst_rel_valid",    64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_out", 64'(out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/bitmask_imm_pipe.md
Name: bitmask_imm_pipe

Overview:
- Pipelined, parametrised generator for the immediate masks of logical-immediate (AND/ORR/EOR/ANDS imm) and bitfield (SBFM/BFM/UBFM) operations.
- Implements full DecodeBitMasks: element-size detection, rotation, replication to M bits, and illegal-encoding detection.
- Sits between issue and the ALU/bitfield functional units.
- Carries an issue tag, has valid/ready flow control, and supports flush.

Parameters:
- M, 64: datapath width; legal values are 32 or 64.
- TAG_W, 7: width of the instruction tag carried alongside each request.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- flush, in, 1: kills all in-flight entries.
- in_valid, in, 1: request valid.
- in_ready, out, 1: block can accept a request this cycle.
- in_tag, in, TAG_W: tag, passed through unchanged.
- in_logical, in, 1: 1 = logical-immediate mode; 0 = bitfield mode.
- in_immN, in, 1: N field.
- in_imms, in, 6: imms field.
- in_immr, in, 6: immr field.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- out_tag, out, TAG_W: tag of the result.
- out_wmask, out, M: wraparound mask; this is the immediate value in logical mode.
- out_tmask, out, M: top mask (bitfield mode).
- out_illegal, out, 1: reserved or unsupported encoding.

Behaviour:
- Reset (asynchronous, rst=1): both stage valids = 0; out_valid = 0; out_tag, out_wmask, out_tmask, out_illegal = 0. in_ready = 1 after reset.
- Latency: 2 cycles from accept (in_valid & in_ready) to out_valid. Throughput is 1 request per cycle when out_ready = 1.
- Stage S1 (registered on accept):
  - len = index of highest set bit of 7-bit {immN, ~imms}. If that value is 0, mark illegal.
  - esize = 1 << len. If esize > M, mark illegal (e.g. immN=1 when M=32).
  - levels = 6-bit (esize-1).
  - Logical mode with (imms & levels) == levels: mark illegal.
  - s = imms & levels; r = immr & levels.
  - Register s, r, len, illegal, logical and tag.
- Stage S2 (output register):
  - welem = ones(s+1) rotated right by r within esize bits.
  - d = 6-bit (s - r) & levels.
  - telem = ones(d+1).
  - out_wmask = welem replicated M/esize times; out_tmask = telem replicated M/esize times.
  - If illegal: out_wmask = out_tmask = 0 and out_illegal = 1.
- Handshake:
  - A stage advances when it is empty or its downstream stage advances.
  - S2 advances when ~out_valid or out_ready.
  - in_ready = ~S1.valid | S1 advance. This is combinational from out_ready; there is no skid buffer.
  - Outputs hold stable while out_valid & ~out_ready.
  - in_valid with in_ready=0 is not accepted. The upstream must hold the request.
- Flush:
  - Clears S1.valid and S2.valid on the next edge.
  - A request presented with in_valid in the flush cycle is dropped.
  - out_valid is 0 the cycle after flush.
  - Data registers need not be cleared.
- Simultaneous events:
  - flush overrides accept and advance.
  - rst overrides everything.
  - S2 drain and S1 refill in the same cycle are both allowed.
- Reset mid-operation: all entries are lost. No output is produced for them.

Decomposition:
- Package bitmask_pkg:
  - enum mask_mode_t {MODE_BITFIELD, MODE_LOGICAL}.
  - struct s1_entry_t {tag, s, r, len, illegal, mode}.
  - function replicate_elem(elem, len) returning M bits.
- Sub-module bitmask_elem_gen: combinational; takes s, r, len and produces welem and telem (64-bit zero-extended). It is instantiated in S2.

Test Plan:
- M=64, logical, N=1, imms=000000, immr=000000 -> after 2 cycles out_wmask=0x0000000000000001, out_illegal=0.
- M=64, logical, N=0, imms=111100, immr=000000 -> out_wmask=0x5555555555555555. Also N=0, imms=000111, immr=000001 -> out_wmask=0x8000007F8000007F.
- Illegal cases, all -> out_illegal=1 with masks 0:
  - logical, N=0, imms=111111.
  - logical, N=1, imms=111111.
  - M=32 instance with N=1, imms=000000.
- M=64, bitfield, N=1, imms=000111, immr=000000 -> out_wmask=0xFF, out_tmask=0xFF. Then immr=001000 -> out_wmask=0xFF00000000000000, out_tmask=0xFFFFFFFFFFFFFFFF.
- Back-to-back stream of 4 tags (1,2,3,4):
  - Hold out_ready=0 for 3 cycles: in_ready falls once both stages are full; outputs stay stable.
  - Release out_ready: tags emerge in order 1,2,3,4, none lost or duplicated.
- With 2 entries in flight, assert flush together with a new in_valid -> no out_valid for any of them.
- Assert rst asynchronously mid-stream -> out_valid drops immediately and in_ready=1 after release.
